// File: rtl/acc_stream_engine.sv
// Stream-arithmetic engine: reduces a programmed number of operand pairs into
// one accumulator under SUM / MAC / GTCNT / MAXDIFF, with a start/busy/done sequencer.
module acc_stream_engine #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  localparam int TW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {M_SUM = 2'b00, M_MAC = 2'b01, M_GTCNT = 2'b10, M_MAXDIFF = 2'b11} mode_t;

  state_t           state, state_nx;
  mode_t            mode_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] accepted;
  logic             s1_valid;
  logic [TW-1:0]    s1_term;
  logic [TW-1:0]    term;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nx;
  logic             carry;
  logic [ACC_W:0]   sum_wide;
  logic             ovf_q;
  logic             accept;
  logic             start_ok;

  assign accept   = in_ready & in_valid;
  assign start_ok = (state == IDLE) & start;
  assign result   = acc;
  assign ovf      = ovf_q;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = (count == '0) ? DONE : RUN;
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = (accepted < count_q);
        if (in_ready && in_valid && (accepted == count_q - CNT_W'(1))) state_nx = DRAIN;
      end
      DRAIN: begin
        // Only stage 1 can hold work here and it retires into acc this cycle.
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    term = '0;
    unique case (mode_q)
      M_SUM:     term = TW'(a) + TW'(b);
      M_MAC:     term = TW'(a) * TW'(b);
      M_GTCNT:   term = TW'(a > b);
      M_MAXDIFF: term = (a > b) ? TW'(a - b) : TW'(b - a);
      default:   term = '0;
    endcase
  end

  always_comb begin
    sum_wide = {1'b0, acc} + (ACC_W + 1)'(s1_term);
    acc_nx   = sum_wide[ACC_W-1:0];
    carry    = sum_wide[ACC_W];
    if (mode_q == M_MAXDIFF) begin
      acc_nx = (ACC_W'(s1_term) > acc) ? ACC_W'(s1_term) : acc;
      carry  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= M_SUM;
      count_q  <= '0;
      accepted <= '0;
      s1_valid <= 1'b0;
      s1_term  <= '0;
      acc      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        mode_q   <= mode_t'(mode);
        count_q  <= count;
        accepted <= '0;
        s1_valid <= 1'b0;
        acc      <= '0;
        ovf_q    <= 1'b0;
      end else begin
        s1_valid <= accept;
        if (accept) begin
          s1_term  <= term;
          accepted <= accepted + CNT_W'(1);
        end
        if (s1_valid) begin
          acc   <= acc_nx;
          ovf_q <= ovf_q | carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_stream_engine.sv
// Directed bench for acc_stream_engine: table of jobs plus hand-written
// reset, count=0/restart and wrap sequences; ACC_W=40 and ACC_W=32 instances.
module tb_acc_stream_engine;

  localparam logic [1:0] SUM = 2'b00, MAC = 2'b01, GTC = 2'b10, MXD = 2'b11;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [1:0]  mode;
  logic [7:0]  count;
  logic [15:0] a, b;
  logic        in_ready, busy, done, ovf;
  logic [39:0] result;
  logic        in_ready32, busy32, done32, ovf32;
  logic [31:0] result32;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] va [0:254];
  logic [15:0] vb [0:254];

  typedef struct {
    logic [1:0]        m;
    int                n;
    int                gap;
    int                inj;
    logic [3:0][15:0]  pa;
    logic [3:0][15:0]  pb;
    logic [39:0]       exp_res;
    logic              exp_ovf;
  } vec_t;

  vec_t tbl [5];

  acc_stream_engine #(.WIDTH(16), .CNT_W(8), .ACC_W(40)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .ovf(ovf)
  );

  acc_stream_engine #(.WIDTH(16), .CNT_W(8), .ACC_W(32)) dut32 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .count(count),
    .in_valid(in_valid), .in_ready(in_ready32), .a(a), .b(b),
    .busy(busy32), .done(done32), .result(result32), .ovf(ovf32)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=0x%0h req=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Start a job in the current cycle s, feed va/vb with 'gap' idle cycles
  // between pairs, optionally pulse start on pair 'inj', then check done timing.
  task automatic run_job(input logic [1:0] m, input int n, input int gap, input int inj,
                         input logic [39:0] exp_res, input logic exp_ovf);
    int s, last, guard;
    s = cyc;
    mode = m; count = 8'(n); start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_s1", 64'(busy), 64'd1);
    check("result_cleared_s1", 64'(result), 64'd0);
    check("ovf_cleared_s1", 64'(ovf), 64'd0);
    if (n == 0) begin
      check("done_s1_count0", 64'(done), 64'd1);
      check("in_ready_count0", 64'(in_ready), 64'd0);
    end
    last = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          tick();
        end
      end
      in_valid = 1'b1; a = va[i]; b = vb[i];
      if (i == inj) begin
        start = 1'b1; mode = SUM; count = 8'd1;
      end
      if (n <= 8) check("in_ready_pair", 64'(in_ready), 64'd1);
      last = cyc - s;
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    if (n > 0) check("in_ready_after_last", 64'(in_ready), 64'd0);
    guard = 0;
    while (done !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    check("done_cycle", 64'(cyc - s), (n == 0) ? 64'd1 : 64'(last + 2));
    check("busy_at_done", 64'(busy), 64'd1);
    check("result", 64'(result), 64'(exp_res));
    check("ovf", 64'(ovf), 64'(exp_ovf));
    tick();
    check("done_single_pulse", 64'(done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    tbl[0] = '{m: SUM, n: 4, gap: 0, inj: -1,
               pa: {16'd7, 16'd5, 16'd3, 16'd1}, pb: {16'd8, 16'd6, 16'd4, 16'd2},
               exp_res: 40'd36, exp_ovf: 1'b0};
    tbl[1] = '{m: MAC, n: 3, gap: 2, inj: -1,
               pa: {16'd0, 16'd10, 16'd2, 16'hFFFF}, pb: {16'd0, 16'd10, 16'd3, 16'hFFFF},
               exp_res: 40'hFFFE006B, exp_ovf: 1'b0};
    tbl[2] = '{m: GTC, n: 4, gap: 0, inj: -1,
               pa: {16'd9, 16'd7, 16'd3, 16'd5}, pb: {16'd0, 16'd7, 16'd5, 16'd3},
               exp_res: 40'd2, exp_ovf: 1'b0};
    tbl[3] = '{m: MXD, n: 4, gap: 1, inj: 2,
               pa: {16'd9, 16'd7, 16'd3, 16'd5}, pb: {16'd0, 16'd7, 16'd5, 16'd3},
               exp_res: 40'd9, exp_ovf: 1'b0};
    tbl[4] = '{m: SUM, n: 2, gap: 0, inj: -1,
               pa: {16'd0, 16'd0, 16'hFFFF, 16'hFFFF}, pb: {16'd0, 16'd0, 16'd1, 16'hFFFF},
               exp_res: 40'h2FFFE, exp_ovf: 1'b0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; mode = SUM; count = '0; a = '0; b = '0;
    tick(); tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    tick();

    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < 4; k++) begin
        va[k] = tbl[j].pa[k];
        vb[k] = tbl[j].pb[k];
      end
      run_job(tbl[j].m, tbl[j].n, tbl[j].gap, tbl[j].inj, tbl[j].exp_res, tbl[j].exp_ovf);
    end

    // Wrap: 255 * 0xFFFE0001 fits in 40 bits but wraps at 32.
    for (int k = 0; k < 255; k++) begin
      va[k] = 16'hFFFF;
      vb[k] = 16'hFFFF;
    end
    run_job(MAC, 255, 0, -1, 40'hFE_FE02_00FF, 1'b0);
    check("wrap32_result", 64'(result32), 64'h0000_0000_FE02_00FF);
    check("wrap32_ovf", 64'(ovf32), 64'd1);

    // count=0, then restart in the cycle right after done.
    run_job(SUM, 0, 0, -1, 40'd0, 1'b0);
    va[0] = 16'd3; vb[0] = 16'd4;
    run_job(SUM, 1, 0, -1, 40'd7, 1'b0);

    // Reset in RUN with 2 of 5 pairs accepted.
    mode = SUM; count = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; a = 16'(k + 10); b = 16'(k + 20);
      tick();
    end
    a = 16'd99; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_ovf", 64'(ovf), 64'd0);
    tick();
    check("midrst_idle_result", 64'(result), 64'd0);
    va[0] = 16'd3; vb[0] = 16'd4;
    run_job(SUM, 1, 0, -1, 40'd7, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
